tff_toggle_ctrl: RTL and testbench

Command-driven toggle sequencer for the toggle flip-flop (`tff`) datapath. It accepts a command over a valid/ready handshake and drives the `tff` `t` input with a programmed number of one-cycle pulses, separated by a programmed gap. It reports completion and the pulse count. It sits between software/test stimulus and the `tff` instance, and optionally shadows the expected `q` to detect datapath mismatches.

---
 rtl/tff_ctrl_pkg.sv | 6 +
 rtl/tff_toggle_ctrl_if.sv | 12 +
 rtl/tff_q_model.sv | 20 ++
 rtl/tff_toggle_ctrl.sv | 77 +++++++
 tb/tb_tff_toggle_ctrl.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/tff_ctrl_pkg.sv
// tff_ctrl_pkg: state encoding and default widths shared by the toggle controller
package tff_ctrl_pkg;
  localparam int TFF_CNT_W = 8;
  localparam int TFF_GAP_W = 4;
  typedef enum logic [1:0] {IDLE, PULSE, GAP, DONE} tff_ctrl_state_e;
endpackage

// File: rtl/tff_toggle_ctrl_if.sv
// tff_toggle_ctrl_if: valid/ready command channel carrying pulse count and gap
interface tff_toggle_ctrl_if import tff_ctrl_pkg::*; #(
  parameter int CNT_W = TFF_CNT_W,
  parameter int GAP_W = TFF_GAP_W
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [CNT_W-1:0] cmd_count;
  logic [GAP_W-1:0] cmd_gap;
  modport master (output cmd_valid, cmd_count, cmd_gap, input cmd_ready);
  modport slave  (input cmd_valid, cmd_count, cmd_gap, output cmd_ready);
endinterface

// File: rtl/tff_q_model.sv
// tff_q_model: shadow of the tff output plus a sticky observed/expected compare
module tff_q_model (
  input  logic clk,
  input  logic rstn,
  input  logic t,
  input  logic q_obs,
  input  logic clr,
  output logic q_exp,
  output logic mismatch
);
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      q_exp    <= 1'b0;
      mismatch <= 1'b0;
    end else begin
      q_exp    <= q_exp ^ t;
      mismatch <= clr ? 1'b0 : mismatch | (q_obs ^ q_exp);
    end
  end
endmodule

// File: rtl/tff_toggle_ctrl.sv
// tff_toggle_ctrl: issues a commanded number of t pulses separated by a programmed gap
// Expected-q checker is built only when TFF_TOGGLE_CTRL_CHECK_EN is defined
module tff_toggle_ctrl import tff_ctrl_pkg::*; #(
  parameter int CNT_W = TFF_CNT_W,
  parameter int GAP_W = TFF_GAP_W
) (
  input  logic             clk,
  input  logic             rstn,
  tff_toggle_ctrl_if.slave cmd,
  output logic             t,
  input  logic             q_obs,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pulses_sent,
  output logic             q_exp,
  output logic             mismatch
);
  tff_ctrl_state_e  state, state_d;
  logic [CNT_W-1:0] remaining;
  logic [GAP_W-1:0] gap_reg, gap_cnt;
  logic             accept;
  assign cmd.cmd_ready = rstn & (state == IDLE);
  assign accept        = cmd.cmd_valid & cmd.cmd_ready;
  assign busy          = state != IDLE;
  assign done          = state == DONE;
  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:    state_d = accept ? ((cmd.cmd_count == '0) ? DONE : PULSE) : IDLE;
      PULSE:   state_d = (remaining == CNT_W'(1)) ? DONE : (gap_reg == '0) ? PULSE : GAP;
      GAP:     state_d = (gap_cnt == GAP_W'(1)) ? PULSE : GAP;
      default: state_d = IDLE;
    endcase
  end
  // t is its own flop, loaded from the next state so it lines up with PULSE
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      t           <= 1'b0;
      remaining   <= '0;
      gap_reg     <= '0;
      gap_cnt     <= '0;
      pulses_sent <= '0;
    end else begin
      state <= state_d;
      t     <= state_d == PULSE;
      if (accept) begin
        remaining   <= cmd.cmd_count;
        gap_reg     <= cmd.cmd_gap;
        pulses_sent <= '0;
      end
      if (state == PULSE) begin
        remaining   <= remaining - 1'b1;
        pulses_sent <= pulses_sent + 1'b1;
        gap_cnt     <= gap_reg;
      end else if (state == GAP) begin
        gap_cnt <= gap_cnt - 1'b1;
      end
    end
  end
`ifdef TFF_TOGGLE_CTRL_CHECK_EN
  tff_q_model u_q_model (
    .clk      (clk),
    .rstn     (rstn),
    .t        (t),
    .q_obs    (q_obs),
    .clr      (accept),
    .q_exp    (q_exp),
    .mismatch (mismatch)
  );
`else
  logic unused_q_obs;
  assign unused_q_obs = q_obs;
  assign q_exp        = 1'b0;
  assign mismatch     = 1'b0;
`endif
endmodule

// File: tb/tb_tff_toggle_ctrl.sv
// tb_tff_toggle_ctrl: table, hand-written and random commands against an arithmetic timing model
module tb_tff_toggle_ctrl;
  localparam int CW = 8;
  localparam int GW = 4;
`ifdef TFF_TOGGLE_CTRL_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  typedef struct {int c; int g; int dcyc; int pulses; bit qend;} vec_t;
  logic          clk = 1'b0;
  logic          rstn = 1'b1;
  logic          t, q_obs, busy, done, q_exp, mismatch;
  logic [CW-1:0] pulses_sent;
  logic          q;
  logic          force_en = 1'b0;
  logic          force_val = 1'b0;
  logic          model_q = 1'b0;
  int            checks = 0;
  int            failures = 0;
  vec_t          vecs[5];

  tff_toggle_ctrl_if #(.CNT_W(CW), .GAP_W(GW)) ifc ();
  tff_toggle_ctrl #(.CNT_W(CW), .GAP_W(GW)) dut (
    .clk(clk), .rstn(rstn), .cmd(ifc), .t(t), .q_obs(q_obs), .busy(busy),
    .done(done), .pulses_sent(pulses_sent), .q_exp(q_exp), .mismatch(mismatch)
  );

  always #5 clk = ~clk;
  always @(posedge clk or negedge rstn) q <= !rstn ? 1'b0 : q ^ t;
  assign q_obs = force_en ? force_val : q;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit exp_t(int n, int c, int g);
    return c > 0 && n >= 1 && (n - 1) % (g + 1) == 0 && (n - 1) / (g + 1) < c;
  endfunction

  function automatic int dur_of(int c, int g);
    return c == 0 ? 1 : c + (c - 1) * g + 1;
  endfunction

  function automatic int pulses_before(int n, int c, int g);
    int s = 0;
    for (int m = 1; m < n; m++) s += int'(exp_t(m, c, g));
    return s;
  endfunction

  task automatic accept(int c, int g, bit drop, output int waited);
    ifc.cmd_valid = 1'b1;
    ifc.cmd_count = CW'(c);
    ifc.cmd_gap   = GW'(g);
    waited = 0;
    while (!ifc.cmd_ready && waited < 64) begin
      @(negedge clk);
      waited++;
    end
    chk("accept_ready", ifc.cmd_ready, 1);
    @(posedge clk);
    #1;
    if (drop) ifc.cmd_valid = 1'b0;
  endtask

  task automatic follow(int c, int g, output int done_at);
    int d;
    int pb;
    logic eq;
    d = dur_of(c, g);
    done_at = 0;
    for (int n = 1; n <= d; n++) begin
      @(negedge clk);
      pb = pulses_before(n, c, g);
      eq = model_q ^ pb[0];
      chk("t", t, exp_t(n, c, g));
      chk("done", done, n == d);
      chk("busy", busy, 1);
      chk("cmd_ready_busy", ifc.cmd_ready, 0);
      chk("pulses_sent", pulses_sent, pb);
      chk("tff_q", q, eq);
      chk("q_exp", q_exp, CHK ? eq : 1'b0);
      chk("mismatch_clear", mismatch, 0);
      if (done && done_at == 0) done_at = n;
    end
    chk("done_cycle", done_at, d);
    model_q ^= c[0];
  endtask

  task automatic idle(int k, int last);
    repeat (k) begin
      @(negedge clk);
      chk("idle_t", t, 0);
      chk("idle_busy", busy, 0);
      chk("idle_done", done, 0);
      chk("idle_ready", ifc.cmd_ready, 1);
      chk("idle_pulses", pulses_sent, last);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    int w, da, c, g;
    vecs = '{'{4, 0, 5, 4, 1'b0}, '{3, 2, 8, 3, 1'b1}, '{0, 0, 1, 0, 1'b1},
             '{1, 5, 2, 1, 1'b0}, '{2, 3, 6, 2, 1'b0}};
    ifc.cmd_valid = 1'b0;
    ifc.cmd_count = '0;
    ifc.cmd_gap   = '0;
    #1 rstn = 1'b0;
    #11;
    chk("rst_ready", ifc.cmd_ready, 0);
    chk("rst_t", t, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pulses", pulses_sent, 0);
    chk("rst_q_exp", q_exp, 0);
    chk("rst_mismatch", mismatch, 0);
    @(negedge clk);
    rstn = 1'b1;
    #1 chk("post_rst_ready", ifc.cmd_ready, 1);
    idle(4, 0);

    foreach (vecs[i]) begin
      accept(vecs[i].c, vecs[i].g, 1'b1, w);
      follow(vecs[i].c, vecs[i].g, da);
      chk("vec_done_cycle", da, vecs[i].dcyc);
      idle(1, vecs[i].pulses);
      chk("vec_pulses", pulses_sent, vecs[i].pulses);
      chk("vec_q_end", q, vecs[i].qend);
    end

    // requester holds a second command through the first one
    accept(2, 1, 1'b0, w);
    ifc.cmd_count = CW'(3);
    ifc.cmd_gap   = '0;
    follow(2, 1, da);
    accept(3, 0, 1'b1, w);
    chk("hold_wait", w, 1);
    follow(3, 0, da);
    idle(2, 3);

    // reset mid-command, during cycle 5 of count=5 gap=1
    accept(5, 1, 1'b1, w);
    repeat (4) @(negedge clk);
    chk("pre_rst_pulses", pulses_sent, 2);
    @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    chk("abort_t", t, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_pulses", pulses_sent, 0);
    chk("abort_ready", ifc.cmd_ready, 0);
    chk("abort_q", q, 0);
    chk("abort_q_exp", q_exp, 0);
    repeat (2) begin
      @(negedge clk);
      chk("abort_hold_done", done, 0);
      chk("abort_hold_t", t, 0);
    end
    rstn = 1'b1;
    model_q = 1'b0;
    idle(2, 0);
    accept(3, 2, 1'b1, w);
    follow(3, 2, da);
    idle(1, 3);

    c = 3;
    repeat (25) begin
      c = $urandom_range(0, 12);
      g = $urandom_range(0, 3);
      accept(c, g, 1'b1, w);
      follow(c, g, da);
      idle($urandom_range(0, 3), c);
    end
    idle(1, c);

    // checker: force a disagreement, expect a sticky flag cleared by accept
    force_en  = 1'b1;
    force_val = ~model_q;
    @(negedge clk);
    chk("mismatch_set", mismatch, CHK);
    force_en = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("mismatch_sticky", mismatch, CHK);
    end
    accept(1, 0, 1'b1, w);
    follow(1, 0, da);
    idle(2, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
